// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the N-channel memory request arbiter:
// FSM state codes, priority-mode values and the timeout-disable constant.
package mem_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_BUSY = 2'd1,
    ST_WR_BUSY = 2'd2,
    ST_DONE    = 2'd3
  } arb_state_t;

  localparam int RR_FIXED = 0;
  localparam int RR_ROUND = 1;
  localparam int TMO_OFF  = 0;

  // Channel index + 1 with wrap, used for the round-robin pointer.
  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_rr_pick.sv
// Request picker (rr_pick): scans the request vector from the pointer (RR)
// or from channel 0 (fixed) and returns the first requesting channel.
module mem_req_arbiter_rr_pick
  import mem_req_arbiter_pkg::*;
#(
  parameter int NCH     = 3,
  parameter int RR_MODE = 1,
  localparam int PW     = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [PW-1:0]  idx,
  output logic           any
);

  logic [PW-1:0] c;

  always_comb begin
    idx = '0;
    any = 1'b0;
    c   = '0;
    for (int k = 0; k < NCH; k++) begin
      c = (RR_MODE == RR_ROUND) ? PW'((int'(ptr) + k) % NCH) : PW'(k);
      if (!any && req[c]) begin
        any = 1'b1;
        idx = c;
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// N-channel arbiter merging read/write requesters onto one shared memory bus,
// one transaction outstanding, with per-channel completion routing and timeout.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int NCH     = 3,
  parameter int ADR_W   = 32,
  parameter int DAT_W   = 32,
  parameter int RR_MODE = 1,
  parameter int TMO_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       ch_rd_req,
  input  logic [NCH-1:0]       ch_rd_w,
  input  logic [NCH-1:0]       ch_rd_hw,
  input  logic [NCH*ADR_W-1:0] ch_rd_adr,
  input  logic [NCH-1:0]       ch_wr_req,
  input  logic [NCH-1:0]       ch_wr_w,
  input  logic [NCH-1:0]       ch_wr_hw,
  input  logic [NCH*ADR_W-1:0] ch_wr_adr,
  input  logic [NCH*DAT_W-1:0] ch_wr_data,
  output logic [NCH-1:0]       ch_rd_valid,
  output logic [DAT_W-1:0]     ch_rd_data,
  output logic [NCH-1:0]       ch_wr_finish,
  output logic [NCH-1:0]       ch_timeout,
  output logic                 read_req,
  output logic                 read_w,
  output logic                 read_hw,
  output logic [ADR_W-1:0]     read_adr,
  input  logic                 read_valid,
  input  logic [DAT_W-1:0]     read_data,
  output logic                 write_req,
  output logic                 write_w,
  output logic                 write_hw,
  output logic [ADR_W-1:0]     write_adr,
  output logic [DAT_W-1:0]     write_data,
  input  logic                 write_finish
);

  localparam int PW       = $clog2(NCH);
  localparam int TW       = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);
  localparam int TMO_LAST = (TMO_CYC > 0) ? TMO_CYC - 1 : 0;

  arb_state_t                 state;
  logic [PW-1:0]              ptr, grant, win;
  logic                       win_vld;
  logic [TW-1:0]              tmo_cnt;
  logic [NCH-1:0]             cand, grant_oh;
  logic [NCH-1:0][ADR_W-1:0]  rd_adr_v, wr_adr_v;
  logic [NCH-1:0][DAT_W-1:0]  wr_data_v;
  logic                       busy, rd_done, wr_done, tmo_hit;

  assign rd_adr_v  = ch_rd_adr;
  assign wr_adr_v  = ch_wr_adr;
  assign wr_data_v = ch_wr_data;
  assign cand      = ch_rd_req | ch_wr_req;

  mem_req_arbiter_rr_pick #(.NCH(NCH), .RR_MODE(RR_MODE)) u_pick (
    .req (cand),
    .ptr (ptr),
    .idx (win),
    .any (win_vld)
  );

  // Completions only count when they match the transaction type in flight;
  // a completion in the last timeout cycle suppresses the abort.
  assign busy     = (state == ST_RD_BUSY) || (state == ST_WR_BUSY);
  assign rd_done  = (state == ST_RD_BUSY) && read_valid;
  assign wr_done  = (state == ST_WR_BUSY) && write_finish;
  assign tmo_hit  = (TMO_CYC != TMO_OFF) && busy && (tmo_cnt == TW'(TMO_LAST))
                    && !rd_done && !wr_done;
  assign grant_oh = NCH'(1) << grant;

  assign ch_rd_valid  = rd_done ? grant_oh : '0;
  assign ch_wr_finish = wr_done ? grant_oh : '0;
  assign ch_timeout   = tmo_hit ? grant_oh : '0;
  assign ch_rd_data   = rd_done ? read_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      grant      <= '0;
      tmo_cnt    <= '0;
      read_req   <= 1'b0;
      read_w     <= 1'b0;
      read_hw    <= 1'b0;
      read_adr   <= '0;
      write_req  <= 1'b0;
      write_w    <= 1'b0;
      write_hw   <= 1'b0;
      write_adr  <= '0;
      write_data <= '0;
    end else begin
      case (state)
        ST_IDLE: if (win_vld) begin
          grant   <= win;
          tmo_cnt <= '0;
          ptr     <= PW'(wrap_inc(int'(win), NCH));
          if (ch_wr_req[win]) begin
            state      <= ST_WR_BUSY;
            write_req  <= 1'b1;
            write_w    <= ch_wr_w[win];
            write_hw   <= ch_wr_hw[win];
            write_adr  <= wr_adr_v[win];
            write_data <= wr_data_v[win];
          end else begin
            state    <= ST_RD_BUSY;
            read_req <= 1'b1;
            read_w   <= ch_rd_w[win];
            read_hw  <= ch_rd_hw[win];
            read_adr <= rd_adr_v[win];
          end
        end
        ST_RD_BUSY, ST_WR_BUSY: begin
          if (rd_done || wr_done || tmo_hit) begin
            state     <= ST_DONE;
            read_req  <= 1'b0;
            write_req <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        // Dead cycle so a just-served requester can drop its stale request.
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
